// File: rtl/ecc_apb_driver_pkg.sv
// ecc_apb_pkg
// Shared definitions for the ECC APB initiator: register offsets of the
// ECC_ENC_DEC block, the operation encoding written to CTRL, and the
// driver FSM state type.
package ecc_apb_pkg;

    // Register offsets inside the ECC_ENC_DEC block (PADDR[3:0])
    localparam logic [3:0] CTRL_OFFSET           = 4'h0;
    localparam logic [3:0] DATA_IN_OFFSET        = 4'h4;
    localparam logic [3:0] CODEWORD_WIDTH_OFFSET = 4'h8;
    localparam logic [3:0] NOISE_OFFSET          = 4'hC;

    typedef enum logic [1:0] {
        ENCODE = 2'd0,
        DECODE = 2'd1,
        FULL   = 2'd2
    } ecc_op_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT_DONE,
        RESP
    } drv_state_e;

    // Write sequence: DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL.
    // CTRL must be last because writing it starts the ECC block.
    function automatic logic [3:0] reg_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_offset = DATA_IN_OFFSET;
            2'd1:    reg_offset = CODEWORD_WIDTH_OFFSET;
            2'd2:    reg_offset = NOISE_OFFSET;
            default: reg_offset = CTRL_OFFSET;
        endcase
    endfunction

endpackage

// File: rtl/ecc_apb_driver_if.sv
// ecc_apb_driver_if
// Bus between the APB initiator and the ECC_ENC_DEC block: APB write
// controls plus the block's completion/result outputs.
//   master: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, observes
//           operation_done/data_out/num_of_errors
//   slave : the opposite directions
interface ecc_apb_driver_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32
);
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       operation_done;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [1:0]                 num_of_errors;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  operation_done, data_out, num_of_errors
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output operation_done, data_out, num_of_errors
    );
endinterface

// File: rtl/ecc_apb_driver.sv
// ecc_apb_driver
// APB initiator that runs one ECC encode/decode transaction: accepts a
// command, writes DATA_IN, CODEWORD_WIDTH, NOISE and CTRL, waits (bounded)
// for operation_done and returns the result on a valid/ready port.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cmd_*             command handshake and fields (op, width, noise, data)
//   bus               APB master side plus ECC completion/result inputs
//   rsp_*             response handshake, captured result, timeout flag
module ecc_apb_driver
    import ecc_apb_pkg::*;
#(
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         AMBA_ADDR_WIDTH = 20,
    parameter int                         AMBA_WORD       = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                         TIMEOUT_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [1:0]            cmd_width,
    input  logic [AMBA_WORD-1:0]  cmd_noise,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    ecc_apb_driver_if.master      bus,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_num_errors,
    output logic                  rsp_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    drv_state_e                 state, next_state;
    logic [1:0]                 reg_idx;
    logic [CNT_W-1:0]           wait_cnt;
    logic                       armed;
    logic [1:0]                 lat_op;
    logic [1:0]                 lat_width;
    logic [AMBA_WORD-1:0]       lat_noise;
    logic [DATA_WIDTH-1:0]      lat_data;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
    logic [AMBA_WORD-1:0]       pwdata_q;
    logic                       psel_c, penable_c, pwrite_c, rsp_valid_c;
    logic                       accept, timeout_hit;

    // Write data for a given register index; all fields are zero-extended
    function automatic logic [AMBA_WORD-1:0] reg_word(
        input logic [1:0]            idx,
        input logic [1:0]            op,
        input logic [1:0]            width,
        input logic [AMBA_WORD-1:0]  noise,
        input logic [DATA_WIDTH-1:0] data
    );
        case (idx)
            2'd0:    reg_word = AMBA_WORD'(data);
            2'd1:    reg_word = AMBA_WORD'(width);
            2'd2:    reg_word = noise;
            default: reg_word = AMBA_WORD'(op);
        endcase
    endfunction

    // armed keeps cmd_ready low while reset is held, even though state is IDLE
    assign cmd_ready   = armed && (state == IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign bus.PSEL    = psel_c;
    assign bus.PENABLE = penable_c;
    assign bus.PWRITE  = pwrite_c;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign rsp_valid   = rsp_valid_c;

    // State register, register index, timeout counter and datapath.
    // PADDR/PWDATA are loaded on the edge that enters SETUP so they are
    // stable across SETUP/ACCESS and simply hold their value when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            reg_idx        <= 2'd0;
            wait_cnt       <= '0;
            armed          <= 1'b0;
            lat_op         <= 2'd0;
            lat_width      <= 2'd0;
            lat_noise      <= '0;
            lat_data       <= '0;
            paddr_q        <= '0;
            pwdata_q       <= '0;
            rsp_data       <= '0;
            rsp_num_errors <= 2'd0;
            rsp_timeout    <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_op    <= cmd_op;
                        lat_width <= cmd_width;
                        lat_noise <= cmd_noise;
                        lat_data  <= cmd_data;
                        reg_idx   <= 2'd0;
                        paddr_q   <= BASE_ADDR | AMBA_ADDR_WIDTH'(reg_offset(2'd0));
                        pwdata_q  <= reg_word(2'd0, cmd_op, cmd_width, cmd_noise, cmd_data);
                    end
                end
                ACCESS: begin
                    if (reg_idx != 2'd3) begin
                        reg_idx  <= reg_idx + 2'd1;
                        paddr_q  <= BASE_ADDR | AMBA_ADDR_WIDTH'(reg_offset(reg_idx + 2'd1));
                        pwdata_q <= reg_word(reg_idx + 2'd1, lat_op, lat_width, lat_noise, lat_data);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                WAIT_DONE: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // done has priority over a timeout in the same cycle
                    if (bus.operation_done) begin
                        rsp_data       <= bus.data_out;
                        rsp_num_errors <= bus.num_of_errors;
                        rsp_timeout    <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data       <= '0;
                        rsp_num_errors <= 2'd0;
                        rsp_timeout    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and APB/response control decode
    always_comb begin
        next_state  = state;
        psel_c      = 1'b0;
        penable_c   = 1'b0;
        pwrite_c    = 1'b0;
        rsp_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = SETUP;
            end
            SETUP: begin
                psel_c     = 1'b1;
                pwrite_c   = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel_c     = 1'b1;
                penable_c  = 1'b1;
                pwrite_c   = 1'b1;
                next_state = (reg_idx == 2'd3) ? WAIT_DONE : SETUP;
            end
            WAIT_DONE: begin
                if (bus.operation_done || timeout_hit) next_state = RESP;
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ecc_apb_driver.sv
// tb_ecc_apb_driver
// Directed self-checking bench for ecc_apb_driver. The bench plays the
// ECC_ENC_DEC block on the interface, checking every APB write cycle by
// cycle and driving operation_done/data_out/num_of_errors on chosen cycles.
module tb_ecc_apb_driver;
    import ecc_apb_pkg::*;

    localparam int             DW   = 32;
    localparam int             AW   = 20;
    localparam int             WW   = 32;
    localparam int             TO   = 16;
    localparam logic [AW-1:0]  BASE = 20'h4_2300;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [1:0]    cmd_width = 2'd0;
    logic [WW-1:0] cmd_noise = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_num_errors;
    logic          rsp_timeout;

    int testsRun = 0;
    int testsFailed = 0;
    int rspCycle;

    ecc_apb_driver_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW), .DATA_WIDTH(DW)) bus ();

    ecc_apb_driver #(
        .DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW),
        .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_width(cmd_width), .cmd_noise(cmd_noise), .cmd_data(cmd_data),
        .bus(bus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_num_errors(rsp_num_errors), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one command and follow it cycle by cycle. Cycle n is sampled 1
    // time unit after edge T0+n. doneAt/spurAt drive operation_done during
    // cycle n (0 = never); resetAt pulls rst low in that cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] width,
                                 input logic [31:0] noise, input logic [31:0] data,
                                 input int doneAt, input int spurAt, input int resetAt,
                                 input logic [31:0] dout, input logic [1:0] nerr,
                                 output int rspAt);
        logic [31:0] expWord [4];
        logic [3:0]  expOff [4];
        int          waitCnt;
        int          n;
        bit          finished;
        expWord = '{data, {30'b0, width}, noise, {30'b0, op}};
        expOff  = '{4'h4, 4'h8, 4'hC, 4'h0};
        bus.operation_done = 1'b0;
        bus.data_out       = dout;
        bus.num_of_errors  = nerr;
        waitCnt = 0;
        while (!cmd_ready && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("cmd_ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_width = width;
        cmd_noise = noise;
        cmd_data  = data;
        @(posedge clk); #1;
        // Scramble the fields so a missing latch shows up on the bus
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_width = ~width;
        cmd_noise = ~noise;
        cmd_data  = ~data;
        n = 1;
        finished = 1'b0;
        rspAt = -1;
        while (!finished) begin
            if (n <= 8) begin
                checkOutput($sformatf("psel_c%0d", n), bus.PSEL, 1);
                checkOutput($sformatf("penable_c%0d", n), bus.PENABLE, (n % 2 == 0));
                checkOutput($sformatf("pwrite_c%0d", n), bus.PWRITE, 1);
                if (n % 2 == 0) begin
                    checkOutput($sformatf("paddr_c%0d", n), bus.PADDR, BASE | AW'(expOff[n/2-1]));
                    checkOutput($sformatf("pwdata_c%0d", n), bus.PWDATA, expWord[n/2-1]);
                end
            end else if (n == 9) begin
                checkOutput("psel_idle_c9", bus.PSEL, 0);
                checkOutput("penable_idle_c9", bus.PENABLE, 0);
            end
            if (rsp_valid) begin
                rspAt = n;
                finished = 1'b1;
            end else if (n == resetAt) begin
                rst = 1'b0;
                #1;
                checkOutput("reset_psel", bus.PSEL, 0);
                checkOutput("reset_penable", bus.PENABLE, 0);
                checkOutput("reset_cmd_ready", cmd_ready, 0);
                checkOutput("reset_paddr", bus.PADDR, 0);
                @(posedge clk); #1;
                rst = 1'b1;
                finished = 1'b1;
            end else if (n >= 40) begin
                checkOutput("rsp_valid_within_budget", 0, 1);
                finished = 1'b1;
            end else begin
                bus.operation_done = (n == doneAt) || (n == spurAt);
                @(posedge clk); #1;
                bus.operation_done = 1'b0;
                n++;
            end
        end
        bus.operation_done = 1'b0;
    endtask

    // Hold the response for 'hold' cycles, then consume it and check the
    // driver returns to IDLE with PADDR/PWDATA still showing the CTRL write.
    task automatic completeResponse(input int hold, input logic [31:0] expData,
                                    input logic [1:0] expErr, input logic expTo,
                                    input logic [1:0] op);
        rsp_ready = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            checkOutput($sformatf("rsp_valid_h%0d", i), rsp_valid, 1);
            checkOutput($sformatf("rsp_data_h%0d", i), rsp_data, expData);
            checkOutput($sformatf("rsp_errors_h%0d", i), rsp_num_errors, expErr);
            checkOutput($sformatf("rsp_timeout_h%0d", i), rsp_timeout, expTo);
            checkOutput($sformatf("cmd_ready_busy_h%0d", i), cmd_ready, 0);
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_ack", rsp_valid, 0);
        checkOutput("cmd_ready_after_ack", cmd_ready, 1);
        checkOutput("paddr_hold_idle", bus.PADDR, BASE);
        checkOutput("pwdata_hold_idle", bus.PWDATA, {30'b0, op});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.operation_done = 1'b0;
        bus.data_out       = '0;
        bus.num_of_errors  = 2'd0;

        // Reset values
        #12;
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_psel", bus.PSEL, 0);
        checkOutput("rst_penable", bus.PENABLE, 0);
        checkOutput("rst_pwrite", bus.PWRITE, 0);
        checkOutput("rst_paddr", bus.PADDR, 0);
        checkOutput("rst_pwdata", bus.PWDATA, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_timeout", rsp_timeout, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("cmd_ready_after_release", cmd_ready, 1);

        // Encode, done in cycle T0+10 -> rsp_valid in T0+11
        applyStimulus(ENCODE, 2'd0, 32'h0, 32'h0000_00A5, 10, 0, 0,
                      32'h0000_5A5A, 2'd0, rspCycle);
        checkOutput("enc_rsp_cycle", rspCycle, 11);
        completeResponse(0, 32'h0000_5A5A, 2'd0, 1'b0, ENCODE);

        // Decode with one noise bit, response held off for 5 cycles
        applyStimulus(DECODE, 2'd1, 32'h0000_0001, 32'hDEAD_BEEF, 12, 0, 0,
                      32'hDEAD_BEEF, 2'd1, rspCycle);
        checkOutput("dec_rsp_cycle", rspCycle, 13);
        completeResponse(5, 32'hDEAD_BEEF, 2'd1, 1'b0, DECODE);

        // Done never arrives -> timeout response at T0+9+16
        applyStimulus(FULL, 2'd2, 32'h8000_0001, 32'h1357_9BDF, 0, 0, 0,
                      32'hFFFF_FFFF, 2'd3, rspCycle);
        checkOutput("to_rsp_cycle", rspCycle, 25);
        completeResponse(0, 32'h0, 2'd0, 1'b1, FULL);

        // Spurious done during SETUP, real done on the timeout cycle
        applyStimulus(DECODE, 2'd3, 32'h0000_0003, 32'h0F0F_0F0F, 24, 3, 0,
                      32'h0F0F_0F0F, 2'd2, rspCycle);
        checkOutput("race_rsp_cycle", rspCycle, 25);
        completeResponse(0, 32'h0F0F_0F0F, 2'd2, 1'b0, DECODE);

        // Reset in the middle of the APB writes, then a clean command
        applyStimulus(FULL, 2'd2, 32'h0000_00F0, 32'h2468_ACE0, 10, 0, 5,
                      32'h1111_2222, 2'd1, rspCycle);
        checkOutput("reset_no_rsp", rspCycle, -1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        applyStimulus(ENCODE, 2'd1, 32'h0000_0002, 32'hCAFE_F00D, 10, 0, 0,
                      32'h0BAD_CAFE, 2'd0, rspCycle);
        checkOutput("post_reset_rsp_cycle", rspCycle, 11);
        completeResponse(0, 32'h0BAD_CAFE, 2'd0, 1'b0, ENCODE);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ecc_apb_driver.md
# ecc_apb_driver

Synthesizable APB initiator that runs one complete ECC encode/decode transaction against the ECC_ENC_DEC register block. It accepts a command on a valid/ready handshake, performs the four register writes over APB, then waits for `operation_done`. It returns `data_out` and `num_of_errors` on a valid/ready response port, which makes it the stimulus end of the bus monitored by the checker.

## Interface
- `DATA_WIDTH`, 32: width of `cmd_data` and `rsp_data`.
- `AMBA_ADDR_WIDTH`, 20: PADDR width.
- `AMBA_WORD`, 32: PWDATA/PRDATA width; must be ≥ DATA_WIDTH.
- `BASE_ADDR`, 0: block base; register offset occupies PADDR[3:0].
- `TIMEOUT_CYCLES`, 16: maximum wait for `operation_done`; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: CTRL value (0 encode, 1 decode, 2 full).
- `cmd_width` in 2: CODEWORD_WIDTH value.
- `cmd_noise` in AMBA_WORD: NOISE value.
- `cmd_data` in DATA_WIDTH: DATA_IN value.
- `PSEL`, `PENABLE`, `PWRITE` out 1 each: APB controls.
- `PADDR` out AMBA_ADDR_WIDTH: APB address.
- `PWDATA` out AMBA_WORD: APB write data.
- `operation_done` in 1: DUT completion.
- `data_out` in DATA_WIDTH: DUT result.
- `num_of_errors` in 2: DUT error count.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out DATA_WIDTH: captured `data_out`.
- `rsp_num_errors` out 2: captured `num_of_errors`.
- `rsp_timeout` out 1: no done within TIMEOUT_CYCLES.

## Operation
- Register map (offsets): CTRL 0x0, DATA_IN 0x4, CODEWORD_WIDTH 0x8, NOISE 0xC.
- PADDR = BASE_ADDR | offset.
- Write order: DATA_IN, CODEWORD_WIDTH, NOISE, CTRL. CTRL is always last because writing CTRL starts the DUT.
- Command fields are latched on acceptance (`cmd_valid && cmd_ready`) and stay stable for the whole transaction.
- `cmd_data` is zero-extended to AMBA_WORD; `cmd_op` and `cmd_width` are zero-extended into PWDATA[1:0].
- FSM states: IDLE → SETUP → ACCESS → (SETUP for next register | WAIT_DONE after CTRL) → RESP → IDLE.
- A 2-bit register index selects PADDR/PWDATA in SETUP/ACCESS.
- SETUP: PSEL=1, PENABLE=0, PWRITE=1.
- ACCESS: PSEL=1, PENABLE=1. There is no PREADY; ACCESS always lasts one cycle.
- WAIT_DONE: a counter is cleared on entry and increments each cycle.
  - `operation_done`=1 → capture `data_out` and `num_of_errors`, `rsp_timeout`=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES → `rsp_data`=0, `rsp_num_errors`=0, `rsp_timeout`=1, go to RESP.
  - Done and timeout in the same cycle → done wins.
- `operation_done` is ignored outside WAIT_DONE.
- RESP: `rsp_valid`=1 and held with stable data until `rsp_ready`=1, then go to IDLE.

## Timing
- Reset values: all outputs 0 (`cmd_ready` is 0 in reset, and 1 in IDLE from the first cycle after reset release), FSM in IDLE, counter 0.
- Accept at edge T0.
  - SETUP DATA_IN in cycle T0+1, ACCESS in T0+2.
  - CODEWORD_WIDTH in T0+3/4, NOISE in T0+5/6, CTRL in T0+7/8.
  - Writes are back-to-back; PSEL stays high from T0+1 to T0+8.
  - PSEL=0 and PENABLE=0 from T0+9.
- WAIT_DONE is entered at T0+9. Done sampled in cycle T0+8+k moves to RESP, so `rsp_valid` is high in cycle T0+9+k.
- Minimum command-to-response: 10 cycles. The next command can be accepted in the cycle after the `rsp_valid && rsp_ready` edge.
- PADDR/PWDATA are stable across each SETUP/ACCESS pair and hold their last value while idle.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronous); the partial APB transfer is abandoned; no response is issued.
- `cmd_valid` while busy: `cmd_ready`=0; the command is not accepted and not lost if held.

## Structure
- Package `ecc_apb_pkg`:
  - register offset localparams;
  - `ecc_op_e` (ENCODE, DECODE, FULL);
  - `drv_state_e` (IDLE, SETUP, ACCESS, WAIT_DONE, RESP).
- Single module with no sub-module. FSM, register index, and timeout counter are in one always_ff with an asynchronous negedge `rst`.

## Test plan
- Encode: op=0, data=0x0000_00A5, width=0, noise=0 → writes 0x4=0xA5, 0x8=0, 0xC=0, 0x0=0 on cycles T0+2/4/6/8; done at T0+10 → `rsp_data`=model value, `rsp_timeout`=0, `rsp_valid` at T0+11.
- Decode with 1-bit noise: noise=0x1 → `rsp_num_errors`=1, data equals original.
- No done ever → `rsp_valid` at T0+9+16 with `rsp_timeout`=1, `rsp_data`=0.
- Backpressure: `rsp_ready`=0 for 5 cycles → `rsp_*` stable and `cmd_ready`=0 throughout; accepted on cycle 6; `cmd_ready`=1 the next cycle.
- `rst` low at T0+5 → PSEL/PENABLE are 0 in the same cycle; after release, a new command completes normally.
- Done on the same cycle as timeout → response has `rsp_timeout`=0 with captured data; a spurious done during SETUP is ignored.
